// File: rtl/riscv_mc_pkg.sv
// Shared encodings for the multi-cycle RISC-V main controller: states, opcodes,
// ALU operations and datapath mux selects.
package riscv_mc_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_JAL      = 4'd10,
    S_JALR1    = 4'd11,
    S_JALR2    = 4'd12,
    S_LUI      = 4'd13
  } state_t;

  typedef enum logic [1:0] {
    ALU_CLS_ADD = 2'd0,
    ALU_CLS_R   = 2'd1,
    ALU_CLS_I   = 2'd2,
    ALU_CLS_BR  = 2'd3
  } alu_cls_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  localparam logic [2:0] ALU_ADD  = 3'b000;
  localparam logic [2:0] ALU_SUB  = 3'b001;
  localparam logic [2:0] ALU_AND  = 3'b010;
  localparam logic [2:0] ALU_OR   = 3'b011;
  localparam logic [2:0] ALU_XOR  = 3'b100;
  localparam logic [2:0] ALU_SLT  = 3'b101;
  localparam logic [2:0] ALU_SLTU = 3'b110;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_REG   = 2'b10;
  localparam logic [1:0] SRCB_REG   = 2'b00;
  localparam logic [1:0] SRCB_IMM   = 2'b01;
  localparam logic [1:0] SRCB_FOUR  = 2'b10;
  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_MEM    = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;
  localparam logic [1:0] RES_IMM    = 2'b11;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

  function automatic logic op_supported(input logic [6:0] op);
    case (op)
      OP_LOAD, OP_STORE, OP_RTYPE, OP_ITYPE,
      OP_BRANCH, OP_JAL, OP_JALR, OP_LUI: op_supported = 1'b1;
      default:                            op_supported = 1'b0;
    endcase
  endfunction

  // blt is taken when slt produced 1 (non-zero); bge when it produced 0.
  function automatic logic branch_taken(input logic [2:0] funct3, input logic zero);
    case (funct3)
      3'b000:  branch_taken = zero;
      3'b001:  branch_taken = ~zero;
      3'b100:  branch_taken = ~zero;
      3'b101:  branch_taken = zero;
      default: branch_taken = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/riscv_mc_controller_alu_decoder.sv
// ALU operation decoder: selects alu_control from the controller's state class
// and the instruction's funct3/funct7b5 fields.
module riscv_alu_decoder
  import riscv_mc_pkg::*;
(
  input  alu_cls_t   i_cls,
  input  logic [2:0] i_funct3,
  input  logic       i_funct7b5,
  output logic [2:0] o_alu_control
);

  always_comb begin
    o_alu_control = ALU_ADD;
    case (i_cls)
      ALU_CLS_R, ALU_CLS_I: begin
        case (i_funct3)
          3'b000:  o_alu_control = (i_cls == ALU_CLS_R && i_funct7b5) ? ALU_SUB : ALU_ADD;
          3'b010:  o_alu_control = ALU_SLT;
          3'b011:  o_alu_control = ALU_SLTU;
          3'b100:  o_alu_control = ALU_XOR;
          3'b110:  o_alu_control = ALU_OR;
          3'b111:  o_alu_control = ALU_AND;
          default: o_alu_control = ALU_ADD;
        endcase
      end
      ALU_CLS_BR: begin
        case (i_funct3)
          3'b000, 3'b001: o_alu_control = ALU_SUB;
          3'b100, 3'b101: o_alu_control = ALU_SLT;
          default:        o_alu_control = ALU_ADD;
        endcase
      end
      default: o_alu_control = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/riscv_mc_controller.sv
// Moore main controller of the multi-cycle RISC-V core: sequences each
// instruction and drives datapath mux selects and write enables.
module riscv_mc_controller
  import riscv_mc_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [6:0] i_op,
  input  logic [2:0] i_funct3,
  input  logic       i_funct7b5,
  input  logic       i_zero,
  output logic       o_pc_write,
  output logic       o_adr_src,
  output logic       o_mem_write,
  output logic       o_ir_write,
  output logic       o_reg_write,
  output logic [1:0] o_result_src,
  output logic [1:0] o_alu_src_a,
  output logic [1:0] o_alu_src_b,
  output logic [2:0] o_imm_src,
  output logic [2:0] o_alu_control,
  output logic       o_illegal_op,
  output logic [3:0] o_state_dbg
);

  localparam state_t RESET_STATE = S_FETCH;

  state_t     r_state;
  alu_cls_t   w_alu_cls;
  logic [2:0] w_alu_control;

  // Reset lands in FETCH at once, so no write strobe of the aborted instruction survives.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= RESET_STATE;
    end else begin
      case (r_state)
        S_FETCH:  r_state <= S_DECODE;
        S_DECODE: begin
          case (i_op)
            OP_LOAD, OP_STORE: r_state <= S_MEMADR;
            OP_RTYPE:          r_state <= S_EXECR;
            OP_ITYPE:          r_state <= S_EXECI;
            OP_BRANCH:         r_state <= S_BRANCH;
            OP_JAL:            r_state <= S_JAL;
            OP_JALR:           r_state <= S_JALR1;
            OP_LUI:            r_state <= S_LUI;
            default:           r_state <= S_FETCH;
          endcase
        end
        S_MEMADR:   r_state <= (i_op == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
        S_MEMREAD:  r_state <= S_MEMWB;
        S_EXECR:    r_state <= S_ALUWB;
        S_EXECI:    r_state <= S_ALUWB;
        S_JAL:      r_state <= S_ALUWB;
        S_JALR1:    r_state <= S_JALR2;
        S_JALR2:    r_state <= S_ALUWB;
        default:    r_state <= S_FETCH;
      endcase
    end
  end

  always_comb begin
    case (r_state)
      S_EXECR:  w_alu_cls = ALU_CLS_R;
      S_EXECI:  w_alu_cls = ALU_CLS_I;
      S_BRANCH: w_alu_cls = ALU_CLS_BR;
      default:  w_alu_cls = ALU_CLS_ADD;
    endcase
  end

  riscv_alu_decoder u_alu_decoder (
    .i_cls         (w_alu_cls),
    .i_funct3      (i_funct3),
    .i_funct7b5    (i_funct7b5),
    .o_alu_control (w_alu_control)
  );

  always_comb begin
    o_pc_write    = 1'b0;
    o_adr_src     = 1'b0;
    o_mem_write   = 1'b0;
    o_ir_write    = 1'b0;
    o_reg_write   = 1'b0;
    o_result_src  = RES_ALUOUT;
    o_alu_src_a   = SRCA_PC;
    o_alu_src_b   = SRCB_REG;
    o_imm_src     = IMM_I;
    o_alu_control = w_alu_control;
    o_illegal_op  = 1'b0;
    case (r_state)
      S_FETCH: begin
        o_ir_write   = 1'b1;
        o_pc_write   = 1'b1;
        o_alu_src_b  = SRCB_FOUR;
        o_result_src = RES_ALU;
      end
      S_DECODE: begin
        o_alu_src_a  = SRCA_OLDPC;
        o_alu_src_b  = SRCB_IMM;
        o_illegal_op = ~op_supported(i_op);
        case (i_op)
          OP_STORE:  o_imm_src = IMM_S;
          OP_BRANCH: o_imm_src = IMM_B;
          OP_JAL:    o_imm_src = IMM_J;
          OP_LUI:    o_imm_src = IMM_U;
          default:   o_imm_src = IMM_I;
        endcase
      end
      S_MEMADR, S_EXECI, S_JALR1: begin
        o_alu_src_a = SRCA_REG;
        o_alu_src_b = SRCB_IMM;
      end
      S_MEMREAD:  o_adr_src = 1'b1;
      S_MEMWB: begin
        o_result_src = RES_MEM;
        o_reg_write  = 1'b1;
      end
      S_MEMWRITE: begin
        o_adr_src   = 1'b1;
        o_mem_write = 1'b1;
      end
      S_EXECR:    o_alu_src_a = SRCA_REG;
      S_ALUWB:    o_reg_write = 1'b1;
      S_BRANCH: begin
        o_alu_src_a = SRCA_REG;
        o_pc_write  = branch_taken(i_funct3, i_zero);
      end
      // Target already sits in ALUOut; the ALU meanwhile forms OldPC+4 for rd.
      S_JAL, S_JALR2: begin
        o_alu_src_a = SRCA_OLDPC;
        o_alu_src_b = SRCB_FOUR;
        o_pc_write  = 1'b1;
      end
      S_LUI: begin
        o_imm_src    = IMM_U;
        o_result_src = RES_IMM;
        o_reg_write  = 1'b1;
      end
      default: o_alu_control = ALU_ADD;
    endcase
  end

  assign o_state_dbg = r_state;

endmodule

// File: tb/tb_riscv_mc_controller.sv
// Directed bench for riscv_mc_controller: a per-instruction state-path model
// with per-state output rules, checked every cycle, plus literal spot checks.
module tb_riscv_mc_controller;
  import riscv_mc_pkg::*;

  logic clk = 1'b0;
  logic rst, funct7b5, zero;
  logic [6:0] op;
  logic [2:0] funct3;
  logic pc_write, adr_src, mem_write, ir_write, reg_write, illegal_op;
  logic [1:0] result_src, alu_src_a, alu_src_b;
  logic [2:0] imm_src, alu_control;
  logic [3:0] state_dbg;

  typedef struct packed {
    logic       pc_write, adr_src, mem_write, ir_write, reg_write;
    logic [1:0] result_src, alu_src_a, alu_src_b;
    logic [2:0] imm_src, alu_control;
    logic       illegal_op;
    logic [3:0] st;
  } outs_t;

  outs_t  exp_o, act_o;
  outs_t  cap [0:7];
  state_t path [$];
  logic   chk_en = 1'b0;
  int     n_tests = 0, n_fail = 0;

  riscv_mc_controller dut (
    .i_clk(clk), .i_rst(rst), .i_op(op), .i_funct3(funct3), .i_funct7b5(funct7b5),
    .i_zero(zero), .o_pc_write(pc_write), .o_adr_src(adr_src), .o_mem_write(mem_write),
    .o_ir_write(ir_write), .o_reg_write(reg_write), .o_result_src(result_src),
    .o_alu_src_a(alu_src_a), .o_alu_src_b(alu_src_b), .o_imm_src(imm_src),
    .o_alu_control(alu_control), .o_illegal_op(illegal_op), .o_state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  assign act_o = {pc_write, adr_src, mem_write, ir_write, reg_write, result_src,
                  alu_src_a, alu_src_b, imm_src, alu_control, illegal_op, state_dbg};

  function automatic logic [2:0] alu_op(input logic [2:0] f3, input logic f7, input logic is_r);
    case (f3)
      3'd0: return (is_r && f7) ? 3'd1 : 3'd0;
      3'd2: return 3'd5;
      3'd3: return 3'd6;
      3'd4: return 3'd4;
      3'd6: return 3'd3;
      3'd7: return 3'd2;
      default: return 3'd0;
    endcase
  endfunction

  function automatic outs_t model_outs(input state_t st, input logic [6:0] o, input logic [2:0] f3,
                                       input logic f7, input logic z);
    outs_t r;
    logic  taken;
    r = '0;
    r.st = st;
    taken = (f3 == 3'd0 && z) || (f3 == 3'd1 && !z) || (f3 == 3'd4 && !z) || (f3 == 3'd5 && z);
    case (st)
      S_FETCH:    begin r.ir_write = 1; r.pc_write = 1; r.alu_src_b = 2'd2; r.result_src = 2'd2; end
      S_DECODE: begin
        r.alu_src_a = 2'd1; r.alu_src_b = 2'd1;
        if (o == 7'h23) r.imm_src = 3'd1;
        else if (o == 7'h63) r.imm_src = 3'd2;
        else if (o == 7'h6F) r.imm_src = 3'd3;
        else if (o == 7'h37) r.imm_src = 3'd4;
        r.illegal_op = !(o inside {7'h03, 7'h23, 7'h33, 7'h13, 7'h63, 7'h6F, 7'h67, 7'h37});
      end
      S_MEMADR:   begin r.alu_src_a = 2'd2; r.alu_src_b = 2'd1; end
      S_MEMREAD:  r.adr_src = 1;
      S_MEMWB:    begin r.result_src = 2'd1; r.reg_write = 1; end
      S_MEMWRITE: begin r.adr_src = 1; r.mem_write = 1; end
      S_EXECR:    begin r.alu_src_a = 2'd2; r.alu_control = alu_op(f3, f7, 1'b1); end
      S_EXECI:    begin r.alu_src_a = 2'd2; r.alu_src_b = 2'd1; r.alu_control = alu_op(f3, f7, 1'b0); end
      S_ALUWB:    r.reg_write = 1;
      S_BRANCH: begin
        r.alu_src_a = 2'd2; r.pc_write = taken;
        r.alu_control = (f3 <= 3'd1) ? 3'd1 : (f3 == 3'd4 || f3 == 3'd5) ? 3'd5 : 3'd0;
      end
      S_JAL, S_JALR2: begin r.alu_src_a = 2'd1; r.alu_src_b = 2'd2; r.pc_write = 1; end
      S_JALR1:    begin r.alu_src_a = 2'd2; r.alu_src_b = 2'd1; end
      S_LUI:      begin r.imm_src = 3'd4; r.result_src = 2'd3; r.reg_write = 1; end
      default:    r = '0;
    endcase
    return r;
  endfunction

  task automatic build_path(input logic [6:0] o);
    path = '{S_FETCH, S_DECODE};
    case (o)
      7'h03: path = '{S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB};
      7'h23: path = '{S_FETCH, S_DECODE, S_MEMADR, S_MEMWRITE};
      7'h33: path = '{S_FETCH, S_DECODE, S_EXECR, S_ALUWB};
      7'h13: path = '{S_FETCH, S_DECODE, S_EXECI, S_ALUWB};
      7'h63: path = '{S_FETCH, S_DECODE, S_BRANCH};
      7'h6F: path = '{S_FETCH, S_DECODE, S_JAL, S_ALUWB};
      7'h67: path = '{S_FETCH, S_DECODE, S_JALR1, S_JALR2, S_ALUWB};
      7'h37: path = '{S_FETCH, S_DECODE, S_LUI};
      default: path = '{S_FETCH, S_DECODE};
    endcase
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      n_tests++;
      if (act_o !== exp_o) begin
        n_fail++;
        $display("FAIL cycle state %0d: got %h expected %h", exp_o.st, act_o, exp_o);
      end
    end
  end

  // Starts and ends at posedge+1 with the DUT in FETCH.
  task automatic run_instr(input logic [31:0] ir, input logic z, input int exp_cycles);
    op = ir[6:0]; funct3 = ir[14:12]; funct7b5 = ir[30]; zero = z;
    build_path(op);
    chk("model_cycles", path.size(), exp_cycles);
    for (int k = 0; k < path.size(); k++) begin
      exp_o  = model_outs(path[k], op, funct3, funct7b5, zero);
      chk_en = 1'b1;
      @(negedge clk);
      cap[k] = act_o;
      @(posedge clk);
      #1;
    end
    chk_en = 1'b0;
    chk("back_to_fetch", state_dbg, 32'd0);
  endtask

  initial begin
    rst = 1'b1; op = 7'd0; funct3 = 3'd0; funct7b5 = 1'b0; zero = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_outputs", act_o, model_outs(S_FETCH, op, funct3, funct7b5, zero));
    chk("reset_literal", {state_dbg, ir_write, pc_write, alu_src_b, result_src}, {4'd0, 1'b1, 1'b1, 2'b10, 2'b10});
    rst = 1'b0;

    run_instr(32'h00002083, 1'b0, 5);
    chk("lw_rw_only_c5", {cap[0].reg_write, cap[1].reg_write, cap[2].reg_write, cap[3].reg_write, cap[4].reg_write}, 32'b00001);
    chk("lw_res_src_c5", cap[4].result_src, 32'd1);
    run_instr(32'h002081B3, 1'b0, 4);
    chk("add_alu", cap[2].alu_control, 32'd0);
    chk("add_rw_c4", cap[3].reg_write, 32'd1);
    run_instr(32'h402081B3, 1'b0, 4);
    chk("sub_alu", cap[2].alu_control, 32'd1);
    run_instr(32'h40008093, 1'b0, 4);
    chk("addi_ignores_f7", cap[2].alu_control, 32'd0);
    run_instr(32'h0020F1B3, 1'b0, 4);
    run_instr(32'h00112223, 1'b0, 4);
    chk("sw_memwrite", cap[3].mem_write, 32'd1);
    run_instr(32'h00208463, 1'b1, 3);
    chk("beq_taken", cap[2].pc_write, 32'd1);
    run_instr(32'h00208463, 1'b0, 3);
    chk("beq_not_taken", cap[2].pc_write, 32'd0);
    run_instr(32'h00209463, 1'b0, 3);
    run_instr(32'h0020C463, 1'b0, 3);
    chk("blt_alu_slt", cap[2].alu_control, 32'd5);
    run_instr(32'h0020D463, 1'b1, 3);
    run_instr(32'h0020E463, 1'b1, 3);
    chk("bltu_not_taken", cap[2].pc_write, 32'd0);
    run_instr(32'h008000EF, 1'b0, 4);
    chk("jal_pcw_res", {cap[2].pc_write, cap[2].result_src}, {1'b1, 2'b00});
    chk("jal_rw_aluwb", cap[3].reg_write, 32'd1);
    run_instr(32'h000080E7, 1'b0, 5);
    run_instr(32'h123450B7, 1'b0, 3);
    chk("lui_res_imm", cap[2].result_src, 32'd3);
    run_instr(32'h0000007F, 1'b0, 2);
    chk("illegal_flag", cap[1].illegal_op, 32'd1);
    chk("illegal_no_writes", {cap[1].reg_write, cap[1].mem_write}, 32'd0);

    op = 7'h33; funct3 = 3'd0; funct7b5 = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2;
    chk("mid_execr_state", state_dbg, 32'd6);
    rst = 1'b1;
    #1;
    chk("mid_rst_outputs", {state_dbg, ir_write, pc_write, reg_write}, {4'd0, 1'b1, 1'b1, 1'b0});
    @(posedge clk);
    #1;
    chk("rst_held_fetch", {state_dbg, reg_write, mem_write}, {4'd0, 1'b0, 1'b0});
    rst = 1'b0;
    run_instr(32'h002081B3, 1'b0, 4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
